conv_weight_sequencer: RTL and testbench
========================================

# conv_weight_sequencer

Sequencer that walks the convolution weight ROM (72 signed 8-bit weights, 3x3 kernel, 8 filters, addr = filter*9 + kernel_index, one-cycle synchronous read) and delivers one complete 3x3 kernel per filter to the conv MAC datapath. It generates ROM addresses, absorbs the ROM read latency, packs the 9 weights into one bus, and hands each kernel over with a valid/ready handshake. It runs either one selected filter or all filters in order. It sits between the top-level conv controller (start/done) and the weight ROM / MAC array.

## Interface
- NUM_FILTERS, 8, filters stored in ROM
- KERNEL_SIZE, 9, weights per filter (3x3x1)
- DATA_W, 8, signed weight width
- ADDR_W, 7, ROM address width
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request, sampled only in IDLE
- all_filters  in  1  sampled with start: 1 = filters 0..NUM_FILTERS-1, 0 = filter_sel only
- filter_sel  in  3  filter index when all_filters=0
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  signed ROM weight_out
- kernel_weights  out  KERNEL_SIZE*DATA_W  packed kernel, weight k at bits [8k+7:8k] (p00 at LSB, p22 at MSB)
- filter_idx  out  3  filter index of kernel_weights
- w_valid  out  1  kernel_weights/filter_idx valid
- w_ready  in  1  consumer accepts when w_valid && w_ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after last kernel accepted

## Operation
- States: IDLE, FETCH, DRAIN, PRESENT, DONE.
- IDLE: start=1 latches mode; first filter = all_filters ? 0 : filter_sel; last filter = all_filters ? NUM_FILTERS-1 : filter_sel; base = first*9; go FETCH.
- Base address kept as running register (+9 per filter); no multiplier.
- FETCH: rom_addr = base + k for k = 0..8, one per cycle; after k=8 go DRAIN.
- Capture pipeline: 2-stage valid/tag shift (tag = k); weight for address issued at edge E is written to slot k at edge E+2.
- DRAIN: wait until slot 8 captured, then w_valid=1, go PRESENT.
- PRESENT: kernel_weights, filter_idx stable while w_valid=1 and w_ready=0. On handshake: if filter_idx == last, go DONE; else filter_idx+1, base+9, w_valid=0, go FETCH.
- DONE: done=1 for one cycle, back to IDLE.
- start outside IDLE ignored; w_ready outside PRESENT ignored.
- rom_data treated as signed, stored unmodified; no arithmetic on weights.

## Timing
- Reset values: rom_addr=0, kernel_weights=0, filter_idx=0, w_valid=0, busy=0, done=0, state IDLE, pipeline valids cleared.
- start sampled at edge E0: rom_addr = base at E0, base+k at E0+k; slot k captured at E0+k+2; w_valid rises at E0+10.
- Start-to-first-valid: 10 cycles. Handshake at edge H: next filter rom_addr = base+9 at H, w_valid again at H+10.
- w_ready held high: all-filter run = 8*11 cycles to last handshake, done pulse the following cycle.
- rom_addr holds last issued value outside FETCH.
- Reset mid-operation: all state and outputs return to reset values on assertion; captured partial kernel discarded; no done pulse.
- Last address issued = 71 (filter 7, k=8); rom_addr never exceeds 71.

## Structure
- Shared package (conv_pkg): NUM_FILTERS, KERNEL_SIZE, DATA_W, ADDR_W, state enum, weight type.
- Single module; no sub-modules. The 2-stage capture pipeline stays inline.

## Test plan
- Bench ROM mem[i]=i; start, all_filters=0, filter_sel=3 -> rom_addr 27..35, w_valid 10 cycles after start, kernel_weights bytes 27..35 (LSB=27), filter_idx=3, done once.
- all_filters=1, w_ready tied high -> 8 kernels, filter_idx 0..7, bytes of kernel f = 9f..9f+8, done 1 cycle after 8th handshake, last rom_addr=71.
- w_ready low 5 cycles in PRESENT -> w_valid, kernel_weights, filter_idx stable; no new ROM fetch until handshake.
- Negative weights (mem[i]=-1-i) -> bytes 0xFF, 0xFE, ... preserved bit-exact.
- start pulses while busy -> ignored, sequence and count unchanged.
- rst asserted mid-FETCH of filter 2 -> all outputs zero immediately; new start runs cleanly from filter 0 with correct data.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the conv weight path.
// Filter geometry, FSM states and the signed weight type.
package conv_pkg;

  localparam int NUM_FILTERS = 8;
  localparam int KERNEL_SIZE = 9;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 7;
  localparam int FIDX_W      = 3;
  localparam int KTAG_W      = 4;
  localparam int KW_W        = KERNEL_SIZE * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  typedef logic signed [DATA_W-1:0] weight_t;

  // filter*9 as shift-and-add, used once per start
  function automatic logic [ADDR_W-1:0] filt_base(
    input logic [FIDX_W-1:0] f
  );
    return {1'b0, f, 3'b000} + {4'b0000, f};
  endfunction

endpackage

// File: rtl/conv_weight_sequencer.sv
// Walks the weight ROM and hands one packed 3x3 kernel per
// filter to the MAC array over a valid/ready handshake.
module conv_weight_sequencer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              all_filters,
  input  logic [FIDX_W-1:0] filter_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  weight_t           rom_data,
  output logic [KW_W-1:0]   kernel_weights,
  output logic [FIDX_W-1:0] filter_idx,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] KSTEP  = ADDR_W'(KERNEL_SIZE);
  localparam logic [KTAG_W-1:0] LAST_K = KTAG_W'(KERNEL_SIZE - 1);
  localparam logic [FIDX_W-1:0] LAST_F = FIDX_W'(NUM_FILTERS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_addr;
  logic [KTAG_W-1:0]   r_k;
  logic [FIDX_W-1:0]   r_fidx;
  logic [FIDX_W-1:0]   r_last;
  logic                r_v1;
  logic                r_v2;
  logic [KTAG_W-1:0]   r_t1;
  logic [KTAG_W-1:0]   r_t2;
  logic [KW_W-1:0]     r_kw;

  logic                w_start;
  logic                w_fetch;
  logic                w_adv;
  logic [FIDX_W-1:0]   w_first;
  logic [ADDR_W-1:0]   w_first_base;

  assign w_start = (r_state == S_IDLE) && start;
  assign w_fetch = (r_state == S_FETCH);
  assign w_adv   = (r_state == S_PRESENT) && w_ready
                   && (r_fidx != r_last);
  assign w_first = all_filters ? '0 : filter_sel;
  assign w_first_base = filt_base(w_first);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start) w_next = S_FETCH;
      S_FETCH:
        if (r_k == LAST_K) w_next = S_DRAIN;
      S_DRAIN:
        if (r_v2 && r_t2 == LAST_K) w_next = S_PRESENT;
      S_PRESENT:
        if (w_ready)
          w_next = (r_fidx == r_last) ? S_DONE : S_FETCH;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    w_valid = (r_state == S_PRESENT);
  end

  // Issue side and the two-stage tag pipe that covers ROM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_addr <= '0;
      r_k    <= '0;
      r_fidx <= '0;
      r_last <= '0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_t1   <= '0;
      r_t2   <= '0;
      r_kw   <= '0;
    end else begin
      r_v1 <= 1'b0;
      r_v2 <= r_v1;
      r_t2 <= r_t1;
      if (r_v2)
        r_kw[r_t2*DATA_W +: DATA_W] <= rom_data;
      unique case (1'b1)
        w_start: begin
          r_base <= w_first_base;
          r_addr <= w_first_base;
          r_fidx <= w_first;
          r_last <= all_filters ? LAST_F : filter_sel;
          r_k    <= KTAG_W'(1);
          r_v1   <= 1'b1;
          r_t1   <= '0;
        end
        w_fetch: begin
          r_addr <= r_base + ADDR_W'(r_k);
          r_k    <= r_k + KTAG_W'(1);
          r_v1   <= 1'b1;
          r_t1   <= r_k;
        end
        w_adv: begin
          r_base <= r_base + KSTEP;
          r_addr <= r_base + KSTEP;
          r_fidx <= r_fidx + FIDX_W'(1);
          r_k    <= KTAG_W'(1);
          r_v1   <= 1'b1;
          r_t1   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rom_addr       = r_addr;
  assign kernel_weights = r_kw;
  assign filter_idx     = r_fidx;

endmodule

// File: tb/tb_conv_weight_sequencer.sv
// Directed and randomized bench for conv_weight_sequencer.
// Kernels are predicted from the ROM contents and filter order.
module tb_conv_weight_sequencer;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        all_filters = 1'b0;
  logic        w_ready = 1'b0;
  logic [2:0]  filter_sel = '0;
  logic [6:0]  rom_addr;
  logic [7:0]  rom_data = '0;
  logic [71:0] kernel_weights;
  logic [2:0]  filter_idx;
  logic        w_valid;
  logic        busy;
  logic        done;

  logic [7:0]  mem [72];
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total = 0;
  int done_cnt = 0;

  conv_weight_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .all_filters(all_filters),
    .filter_sel(filter_sel),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .kernel_weights(kernel_weights),
    .filter_idx(filter_idx),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data <= (rom_addr < 7'd72) ? mem[rom_addr] : 8'h00;

  always @(posedge clk)
    if (done) done_cnt <= done_cnt + 1;

  task automatic chk(string tag, logic [71:0] obs,
                     logic [71:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] kern(int f);
    logic [71:0] v;
    for (int k = 0; k < 9; k++)
      v[8*k +: 8] = mem[9*f + k];
    return v;
  endfunction

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic run(bit all, logic [2:0] sel, int stall,
                     bit poke);
    int first;
    int last;
    int d0;
    int n;
    logic [71:0] exp;
    first = all ? 0 : int'(sel);
    last  = all ? 7 : int'(sel);
    d0 = done_cnt;
    start = 1'b1;
    all_filters = all;
    filter_sel = sel;
    w_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int f = first; f <= last; f++) begin
      exp = kern(f);
      for (int c = 0; c < 10; c++) begin
        if (c < 9)
          chk("rom_addr", rom_addr, 72'(9*f + c));
        chk("valid_low", w_valid, 0);
        w_ready = 1'($urandom_range(0, 1));
        if (poke) begin
          start = 1'($urandom_range(0, 1));
          all_filters = 1'($urandom_range(0, 1));
          filter_sel = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
      end
      start = 1'b0;
      chk("valid_high", w_valid, 1);
      chk("kernel", kernel_weights, exp);
      chk("filter_idx", filter_idx, 72'(f));
      chk("busy_run", busy, 1);
      n = (stall >= 0) ? stall : int'($urandom_range(0, 4));
      w_ready = 1'b0;
      repeat (n) begin
        @(negedge clk);
        chk("stall_valid", w_valid, 1);
        chk("stall_kernel", kernel_weights, exp);
        chk("stall_fidx", filter_idx, 72'(f));
        chk("stall_addr", rom_addr, 72'(9*f + 8));
      end
      w_ready = 1'b1;
      @(negedge clk);
      w_ready = 1'b0;
    end
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
    chk("done_count", 72'(done_cnt - d0), 1);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 72; i++) mem[i] = 8'(i);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_addr", rom_addr, 0);
    chk("rst_kernel", kernel_weights, 0);
    chk("rst_fidx", filter_idx, 0);
    chk("rst_valid", w_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 3'd3, 0, 1'b0);
    run(1'b1, 3'd0, 0, 1'b0);
    chk("last_addr", rom_addr, 71);
    run(1'b0, 3'd5, 5, 1'b0);

    for (int i = 0; i < 72; i++) mem[i] = 8'(-1 - i);
    run(1'b0, 3'd0, 2, 1'b0);
    run(1'b0, 3'd7, 0, 1'b0);

    for (int i = 0; i < 72; i++) mem[i] = 8'(i);
    run(1'b1, 3'd0, -1, 1'b1);

    start = 1'b1;
    all_filters = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w_ready = 1'b1;
    repeat (26) @(negedge clk);
    chk("mid_addr", rom_addr, 22);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_kernel", kernel_weights, 0);
    chk("mid_rst_fidx", filter_idx, 0);
    chk("mid_rst_valid", w_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    w_ready = 1'b0;
    @(negedge clk);
    chk("rst_no_done", 72'(done_cnt - d0), 0);
    run(1'b1, 3'd0, 0, 1'b0);

    for (int i = 0; i < 72; i++) mem[i] = 8'($urandom);
    repeat (4)
      run(1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), -1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
